bnn_layer_sequencer: RTL and testbench



---
 rtl/bnn_layer_sequencer_if.sv | 38 +++
 rtl/bnn_layer_sequencer.sv | 144 ++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_sequencer_if.sv
// Handshake and memory-control bundle between a layer sequencer and its
// surroundings. Widths are derived from the layer geometry.
interface bnn_layer_sequencer_if #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 128,
    parameter int W     = 16
);
    localparam int N_WORDS = (N_IN + W - 1) / W;
    localparam int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int WAW     = (N_OUT * N_WORDS > 1) ? $clog2(N_OUT * N_WORDS) : 1;
    localparam int NW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic           start;
    logic           stall;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  act_addr;
    logic [WAW-1:0] w_addr;
    logic           acc_clr;
    logic           acc_en;
    logic [W-1:0]   valid_mask;
    logic           thr_en;
    logic           out_we;
    logic [NW-1:0]  neuron_idx;

    modport master (
        output start, stall,
        input  busy, done, rd_en, act_addr, w_addr, acc_clr, acc_en,
               valid_mask, thr_en, out_we, neuron_idx
    );

    modport slave (
        input  start, stall,
        output busy, done, rd_en, act_addr, w_addr, acc_clr, acc_en,
               valid_mask, thr_en, out_we, neuron_idx
    );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Per-layer sequencer for the XNOR-popcount datapath: walks every output
// neuron, streams its activation/weight words, then thresholds and writes
// the output bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; counters parked at 0
// S_FETCH  | issuing one activation/weight word read per cycle
// S_DRAIN  | last word's read data accumulates
// S_THRESH | compare accumulator, write output bit, clear accumulator
// S_DONE   | one-cycle done pulse, then back to idle
module bnn_layer_sequencer #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 128,
    parameter int W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bnn_layer_sequencer_if.slave  bus
);
    localparam int N_WORDS = (N_IN + W - 1) / W;
    localparam int REM     = N_IN % W;
    localparam int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int WAW     = (N_OUT * N_WORDS > 1) ? $clog2(N_OUT * N_WORDS) : 1;
    localparam int NW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [AW-1:0] K_LAST    = AW'(N_WORDS - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(N_OUT - 1);
    localparam logic [W-1:0]  LAST_MASK = (REM == 0) ? {W{1'b1}}
                                                     : ({W{1'b1}} >> (W - REM));

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_THRESH,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  k_q;
    logic [NW-1:0]  n_q;
    logic [WAW-1:0] w_addr_q;
    logic           acc_en_q;
    logic [W-1:0]   mask_q;
    logic           rd_en_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stall freezes every non-idle state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FETCH;
            S_FETCH:  if (!bus.stall && k_q == K_LAST) state_nxt = S_DRAIN;
            S_DRAIN:  if (!bus.stall) state_nxt = S_THRESH;
            S_THRESH: if (!bus.stall) state_nxt = (n_q == N_LAST) ? S_DONE : S_FETCH;
            S_DONE:   if (!bus.stall) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobe outputs; acc_clr is gated with rst_n so it stays low while reset is held.
    always_comb begin
        bus.busy    = (state != S_IDLE);
        rd_en_c     = (state == S_FETCH) && !bus.stall;
        bus.thr_en  = (state == S_THRESH) && !bus.stall;
        bus.out_we  = (state == S_THRESH) && !bus.stall;
        bus.done    = (state == S_DONE) && !bus.stall;
        bus.acc_clr = ((state == S_IDLE) && bus.start && rst_n) ||
                      ((state == S_THRESH) && !bus.stall);
        bus.rd_en   = rd_en_c;
    end

    // Word, neuron and weight-address counters; w_addr tracks neuron*N_WORDS + k
    // incrementally so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            n_q      <= '0;
            w_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        k_q      <= '0;
                        n_q      <= '0;
                        w_addr_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (!bus.stall && k_q != K_LAST) begin
                        k_q      <= k_q + AW'(1);
                        w_addr_q <= w_addr_q + WAW'(1);
                    end
                end
                S_THRESH: begin
                    if (!bus.stall && n_q != N_LAST) begin
                        k_q      <= '0;
                        n_q      <= n_q + NW'(1);
                        w_addr_q <= w_addr_q + WAW'(1);
                    end
                end
                S_DONE: begin
                    if (!bus.stall) begin
                        k_q      <= '0;
                        n_q      <= '0;
                        w_addr_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulate enable and bit mask follow the read by one cycle to meet the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_en_q <= 1'b0;
            mask_q   <= '0;
        end else begin
            acc_en_q <= rd_en_c;
            if (rd_en_c) begin
                mask_q <= (k_q == K_LAST) ? LAST_MASK : {W{1'b1}};
            end else begin
                mask_q <= '0;
            end
        end
    end

    assign bus.act_addr   = k_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.neuron_idx = n_q;
    assign bus.acc_en     = acc_en_q;
    assign bus.valid_mask = mask_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: small layer (20 bits, 3 neurons) checked
// cycle by cycle against a scoreboard, plus a default-sized layer for mask
// and latency checks.
module tb_bnn_layer_sequencer;
    localparam int S_NWD = 2;
    localparam int S_NO  = 3;
    localparam int S_AW  = 1;
    localparam int S_WAW = 3;
    localparam int S_NW  = 2;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             rd_en;
        logic             acc_clr;
        logic             acc_en;
        logic             thr_en;
        logic             out_we;
        logic [S_AW-1:0]  act_addr;
        logic [S_WAW-1:0] w_addr;
        logic [15:0]      valid_mask;
        logic [S_NW-1:0]  neuron_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bnn_layer_sequencer_if #(.N_IN(20), .N_OUT(3), .W(16)) bus ();
    bnn_layer_sequencer_if #(.N_IN(784), .N_OUT(128), .W(16)) bus_big ();

    bnn_layer_sequencer #(.N_IN(20), .N_OUT(3), .W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    bnn_layer_sequencer #(.N_IN(784), .N_OUT(128), .W(16)) dut_big (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_big)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    string cur_test = "init";
    int    cur_cyc = 0;
    vec_t  sb_q[$];
    vec_t  trace[$];
    vec_t  obs[$];

    function automatic vec_t sample();
        vec_t v;
        v.busy       = bus.busy;
        v.done       = bus.done;
        v.rd_en      = bus.rd_en;
        v.acc_clr    = bus.acc_clr;
        v.acc_en     = bus.acc_en;
        v.thr_en     = bus.thr_en;
        v.out_we     = bus.out_we;
        v.act_addr   = bus.act_addr;
        v.w_addr     = bus.w_addr;
        v.valid_mask = bus.valid_mask;
        v.neuron_idx = bus.neuron_idx;
        return v;
    endfunction

    function automatic logic [15:0] exp_mask(input int k);
        return (k == S_NWD - 1) ? 16'h000F : 16'hFFFF;
    endfunction

    // Reference trace of one layer started at cycle 0, with an optional stall window.
    task automatic gen_trace(input int stall_from, input int stall_len);
        vec_t v;
        int   phase, n, k, prev_k, c;
        logic prev_rd, st, rd;
        trace.delete();
        v = '0;
        v.acc_clr = 1'b1;
        trace.push_back(v);
        phase = 0; n = 0; k = 0; prev_k = 0; prev_rd = 1'b0;
        for (c = 1; c < 200; c++) begin
            st = (c >= stall_from) && (c < stall_from + stall_len);
            rd = (phase == 0) && !st;
            v = '0;
            v.busy       = 1'b1;
            v.act_addr   = S_AW'(k);
            v.w_addr     = S_WAW'(n * S_NWD + k);
            v.neuron_idx = S_NW'(n);
            v.acc_en     = prev_rd;
            v.valid_mask = prev_rd ? exp_mask(prev_k) : 16'h0000;
            v.rd_en      = rd;
            v.thr_en     = (phase == 2) && !st;
            v.out_we     = (phase == 2) && !st;
            v.acc_clr    = (phase == 2) && !st;
            v.done       = (phase == 3) && !st;
            trace.push_back(v);
            prev_rd = rd;
            prev_k  = k;
            if (!st) begin
                if (phase == 0) begin
                    if (k == S_NWD - 1) phase = 1;
                    else k++;
                end else if (phase == 1) begin
                    phase = 2;
                end else if (phase == 2) begin
                    if (n < S_NO - 1) begin
                        n++; k = 0; phase = 0;
                    end else begin
                        phase = 3;
                    end
                end else begin
                    break;
                end
            end
        end
    endtask

    // Drive one layer; expected vectors go to the scoreboard as each cycle is driven.
    task automatic run_layer(input string name, input int stall_from, input int stall_len,
                             input int extra_start, input int abort_at);
        cur_test = name;
        gen_trace(stall_from, stall_len);
        obs.delete();
        for (int c = 0; c < trace.size(); c++) begin
            @(posedge clk);
            #1;
            if (c == abort_at) return;
            bus.start = (c == 0) || (c == extra_start);
            bus.stall = (c >= stall_from) && (c < stall_from + stall_len);
            cur_cyc = c;
            sb_q.push_back(trace[c]);
            @(negedge clk);
            obs.push_back(sample());
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        vec_t z;
        z = '0;
        cur_test = "reset";
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus_big.start = 1'b0;
        bus_big.stall = 1'b0;
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (sample() !== z) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=%h", sample(), z);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            cur_cyc = c;
            sb_q.push_back(z);
            @(negedge clk);
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_busy cycle %0d got=%b exp=0", c, bus.busy);
            end
        end
    endtask

    task automatic test_nominal();
        int exp_rd[6] = '{1, 2, 5, 6, 9, 10};
        int exp_thr[3] = '{4, 8, 12};
        int i;
        run_layer("nominal", -1, 0, -1, -1);
        i = 0;
        for (int c = 0; c < obs.size(); c++) begin
            if (obs[c].rd_en) begin
                n_cmp++;
                if (i >= 6 || c != exp_rd[i] || obs[c].w_addr !== S_WAW'(i)) begin
                    n_err++;
                    $display("FAIL nominal_rd #%0d got cycle=%0d w_addr=%0d exp cycle=%0d w_addr=%0d",
                             i, c, obs[c].w_addr, (i < 6) ? exp_rd[i] : -1, i);
                end
                i++;
            end
        end
        n_cmp++;
        if (i != 6) begin
            n_err++;
            $display("FAIL nominal_rd_count got=%0d exp=6", i);
        end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (obs[exp_thr[j]].thr_en !== 1'b1 || obs[exp_thr[j]].out_we !== 1'b1 ||
                obs[exp_thr[j]].neuron_idx !== S_NW'(j)) begin
                n_err++;
                $display("FAIL nominal_thr cycle %0d got thr=%b we=%b n=%0d exp thr=1 we=1 n=%0d",
                         exp_thr[j], obs[exp_thr[j]].thr_en, obs[exp_thr[j]].out_we,
                         obs[exp_thr[j]].neuron_idx, j);
            end
        end
        n_cmp++;
        if (obs.size() != 14 || obs[13].done !== 1'b1 || obs[0].acc_clr !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_done got len=%0d done13=%b clr0=%b exp len=14 done13=1 clr0=1",
                     obs.size(), obs[obs.size()-1].done, obs[0].acc_clr);
        end
    endtask

    task automatic test_mask();
        int cnt;
        run_layer("mask", -1, 0, -1, -1);
        cnt = 0;
        for (int c = 0; c < obs.size(); c++) begin
            if (obs[c].acc_en) begin
                n_cmp++;
                if (obs[c].valid_mask !== ((cnt % 2 == 1) ? 16'h000F : 16'hFFFF)) begin
                    n_err++;
                    $display("FAIL mask_acc #%0d got=%h exp=%h", cnt, obs[c].valid_mask,
                             (cnt % 2 == 1) ? 16'h000F : 16'hFFFF);
                end
                cnt++;
            end
        end
    endtask

    task automatic test_stall();
        run_layer("stall", 2, 3, -1, -1);
        n_cmp++;
        if (obs[2].acc_en !== 1'b1 || obs[3].acc_en !== 1'b0) begin
            n_err++;
            $display("FAIL stall_acc_en got c2=%b c3=%b exp c2=1 c3=0", obs[2].acc_en, obs[3].acc_en);
        end
        for (int c = 2; c <= 4; c++) begin
            n_cmp++;
            if (obs[c].act_addr !== 1'b1 || obs[c].rd_en !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d got addr=%0d rd=%b exp addr=1 rd=0",
                         c, obs[c].act_addr, obs[c].rd_en);
            end
        end
        n_cmp++;
        if (obs[5].rd_en !== 1'b1 || obs[5].act_addr !== 1'b1) begin
            n_err++;
            $display("FAIL stall_resume got rd=%b addr=%0d exp rd=1 addr=1", obs[5].rd_en, obs[5].act_addr);
        end
        n_cmp++;
        if (obs.size() != 17 || obs[16].done !== 1'b1) begin
            n_err++;
            $display("FAIL stall_done got len=%0d exp len=17 with done at 16", obs.size());
        end
    endtask

    task automatic test_back_to_back();
        int dcnt;
        run_layer("busy_start", -1, 0, 5, -1);
        dcnt = 0;
        foreach (obs[c]) if (obs[c].done) dcnt++;
        n_cmp++;
        if (dcnt != 1 || obs[13].done !== 1'b1) begin
            n_err++;
            $display("FAIL busy_start_done got count=%0d exp=1", dcnt);
        end
        run_layer("restart", -1, 0, -1, -1);
        n_cmp++;
        if (obs[1].rd_en !== 1'b1 || obs[13].done !== 1'b1) begin
            n_err++;
            $display("FAIL restart got rd1=%b done13=%b exp 1 1", obs[1].rd_en, obs[13].done);
        end
    endtask

    task automatic test_reset_mid_run();
        vec_t z;
        z = '0;
        run_layer("abort", -1, 0, -1, 7);
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        n_cmp++;
        if (sample() !== z) begin
            n_err++;
            $display("FAIL abort_outputs got=%h exp=%h", sample(), z);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_quiet got done=%b busy=%b exp 0 0", bus.done, bus.busy);
            end
        end
        rst_n = 1'b1;
        run_layer("after_abort", -1, 0, -1, -1);
        n_cmp++;
        if (obs[4].neuron_idx !== '0 || obs[4].thr_en !== 1'b1 || obs[13].done !== 1'b1) begin
            n_err++;
            $display("FAIL after_abort got n=%0d thr=%b done=%b exp n=0 thr=1 done=1",
                     obs[4].neuron_idx, obs[4].thr_en, obs[13].done);
        end
    endtask

    task automatic test_default_mask();
        int done_c;
        done_c = -1;
        cur_test = "default";
        for (int c = 0; c < 7000; c++) begin
            @(posedge clk);
            #1;
            bus_big.start = (c == 0);
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if (bus_big.valid_mask !== (bus_big.acc_en ? 16'hFFFF : 16'h0000)) begin
                    n_err++;
                    $display("FAIL default_mask cycle %0d got=%h acc_en=%b", c,
                             bus_big.valid_mask, bus_big.acc_en);
                end
                if (bus_big.rd_en && bus_big.w_addr > 13'd6271) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL default_w_addr cycle %0d got=%0d exp<=6271", c, bus_big.w_addr);
                end
                if (bus_big.done) begin
                    done_c = c;
                    break;
                end
            end
        end
        bus_big.start = 1'b0;
        n_cmp++;
        if (done_c != 6529) begin
            n_err++;
            $display("FAIL default_done_cycle got=%0d exp=6529", done_c);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (sb_q.size() > 0) begin
                    vec_t e, g;
                    e = sb_q.pop_front();
                    g = sample();
                    n_cmp++;
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL %s_cycle%0d got=%h exp=%h", cur_test, cur_cyc, g, e);
                    end
                end
            end
        join_none
        test_reset();
        test_nominal();
        test_mask();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_default_mask();
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
